// File: rtl/parity_check_sequencer.sv
// parity_check_sequencer
// Checks even parity on parallel words by folding them one bit per cycle
// through a single serial XOR stage.
// Flow: accept a word (data + parity bit), fold DATA_W bits, then present a
// pass/fail result.
// Optional feature macro: ERR_CNT_EN.
//   Defined   - builds a saturating counter of errored results.
//   Undefined - err_cnt is tied to 0 and cnt_clr is ignored.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both 1. The valid side holds its payload stable until
// that edge, and valid never depends combinationally on ready.
`timescale 1ns/1ps

module parity_check_sequencer #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_pb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic              busy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              fold;
    logic              finish;
    logic              out_fire;
    logic [DATA_W-1:0] data;
    logic              acc;
    logic [IDX_W-1:0]  idx;
    logic              bit_sel;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the single-cycle control strobes for the datapath
    always_comb begin
        state_next = state;
        load       = 1'b0;
        fold       = 1'b0;
        finish     = 1'b0;
        out_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                fold = 1'b1;
                if (idx == LAST_IDX) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // out_valid is high throughout DONE, so ready alone completes it
                if (out_ready) begin
                    out_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Serial checker input: the data bit selected by idx
    always_comb begin
        bit_sel = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (idx == IDX_W'(i)) begin
                bit_sel = data[i];
            end
        end
    end

    // Datapath: latch word, fold one bit per cycle, register the result
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            acc       <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (load) begin
                data <= in_data;
                acc  <= in_pb;
                idx  <= '0;
            end
            if (fold) begin
                acc <= acc ^ bit_sel;
                // idx parks on the last bit rather than stepping past it
                if (!finish) begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (finish) begin
                out_valid <= 1'b1;
                out_err   <= acc ^ bit_sel;
            end
            if (out_fire) begin
                out_valid <= 1'b0;
                out_err   <= 1'b0;
            end
        end
    end

`ifdef ERR_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of errored results; a clear beats a same-edge increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (out_fire && out_err && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign err_cnt = cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_parity_check_sequencer.sv
// tb_parity_check_sequencer
// Directed bench for parity_check_sequencer (DATA_W=3, CNT_W=2).
// Expected error bits are hand-computed per vector. The counter expectation
// follows ERR_CNT_EN the same way the design does.
`timescale 1ns/1ps

module tb_parity_check_sequencer;

    localparam int DATA_W = 3;
    localparam int CNT_W  = 2;
`ifdef ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_pb;
    logic              out_valid;
    logic              out_ready;
    logic              out_err;
    logic              busy;
    logic              cnt_clr;
    logic [CNT_W-1:0]  err_cnt;

    logic [0:0] exp_q[$];
    int         exp_cnt;
    int         n_checks;
    int         n_fail;

    parity_check_sequencer #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_pb    (in_pb),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_err  (out_err),
        .busy     (busy),
        .cnt_clr  (cnt_clr),
        .err_cnt  (err_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present one word for one edge (block must be idle), then scramble inputs
    task automatic accept_word(input logic [DATA_W-1:0] d, input logic pb, input logic e);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_pb    = pb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom_range(0, 7));
        in_pb    = 1'($urandom_range(0, 1));
        exp_q.push_back(e);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Wait for the result, optionally stall the consumer, then take it
    task automatic collect(input logic clr, input int stall);
        int         cycles;
        logic [0:0] exp_e;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("result_latency", 32'(cycles), 32'(DATA_W));
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check("out_err", 32'(out_err), 32'(exp_e));
        check("busy_in_done", 32'(busy), 32'd1);
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1;
                in_data  = '0;
                in_pb    = 1'b0;
                @(posedge clk);
                #1;
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_out_err", 32'(out_err), 32'(exp_e));
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        cnt_clr = clr;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        if (CNT_EN) begin
            if (clr) exp_cnt = 0;
            else if (exp_e == 1'b1 && exp_cnt != 3) exp_cnt = exp_cnt + 1;
        end
        check("out_valid_after_take", 32'(out_valid), 32'd0);
        check("in_ready_after_take", 32'(in_ready), 32'd1);
        check("busy_after_take", 32'(busy), 32'd0);
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int stray;
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pb     = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_err", 32'(out_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);

        // Basic vectors: 101/0 ok, 100/0 error, 111/1 ok, 000/1 error, 011/1 error, 110/0 ok
        accept_word(3'b101, 1'b0, 1'b0); collect(1'b0, 0);
        accept_word(3'b100, 1'b0, 1'b1); collect(1'b0, 0);
        accept_word(3'b111, 1'b1, 1'b0); collect(1'b0, 0);
        accept_word(3'b000, 1'b1, 1'b1); collect(1'b0, 0);
        accept_word(3'b011, 1'b1, 1'b1); collect(1'b0, 0);
        accept_word(3'b110, 1'b0, 1'b0); collect(1'b0, 0);

        // Consumer stall of 5 cycles with in_valid pushed during DONE
        accept_word(3'b010, 1'b0, 1'b1); collect(1'b0, 5);
        stray = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1 || busy === 1'b1) stray++;
        end
        check("no_accept_during_done", 32'(stray), 32'd0);

        // Clear on its own while idle
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check("err_cnt_clear_idle", 32'(err_cnt), 32'd0);

        // Five errored words saturate a 2-bit counter at 3
        for (int i = 0; i < 5; i++) begin
            accept_word(3'b001, 1'b0, 1'b1);
            collect(1'b0, 0);
        end
        check("err_cnt_saturated", 32'(err_cnt), CNT_EN ? 32'd3 : 32'd0);

        // Clear on the same edge as a sixth error handshake
        accept_word(3'b001, 1'b0, 1'b1);
        collect(1'b1, 0);
        check("err_cnt_clear_wins", 32'(err_cnt), 32'd0);

        // Put one error in the counter, then reset in the middle of SHIFT
        accept_word(3'b100, 1'b0, 1'b1); collect(1'b0, 0);
        accept_word(3'b100, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_err_cnt", 32'(err_cnt), 32'd0);
        stray = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) stray++;
        end
        check("no_result_after_reset", 32'(stray), 32'd0);

        // Recovery after reset
        accept_word(3'b001, 1'b1, 1'b0); collect(1'b0, 0);
        accept_word(3'b110, 1'b1, 1'b1); collect(1'b0, 0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
